wb_irq_ctrl: RTL and testbench
==============================

WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, the number of interrupt source inputs (legal range 1..32).
REQ-002 SHALL have port wb_clk  input  1  system clock; every flop samples on its rising edge.
REQ-003 SHALL have port wb_rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wb_adr  input  32  byte address; only bits [4:2] are decoded.
REQ-005 SHALL have port wb_dat  input  32  write data.
REQ-006 SHALL have port wb_sel  input  4  byte-lane write enables.
REQ-007 SHALL have port wb_we  input  1  write strobe.
REQ-008 SHALL have port wb_cyc  input  1  bus cycle valid.
REQ-009 SHALL have port wb_stb  input  1  slave select.
REQ-010 SHALL have port wb_rdt  output  32  read data.
REQ-011 SHALL have port wb_ack  output  1  transfer acknowledge.
REQ-012 SHALL have port irq_src  input  NUM_IRQ  interrupt sources, synchronous to wb_clk, active-high.
REQ-013 SHALL have port irq_o  output  1  aggregated interrupt request to the core's interrupt_external input.

Function
REQ-014 SHALL decode the register map by wb_adr[4:2]: 0 PENDING (R/W1C), 1 ENABLE (RW), 2 STATUS = PENDING & ENABLE (R), 3 TRIGGER (RW, 1 = edge), 4 CLAIM (R); all other offsets read 0 and ignore writes.
REQ-015 SHALL assert wb_ack one cycle after sampling wb_cyc & wb_stb & !wb_ack, hold it for exactly one cycle, and never assert it on two consecutive cycles.
REQ-016 SHALL drive wb_rdt with the addressed register in the wb_ack cycle and 0 in all other cycles; register bits at or above NUM_IRQ read 0.
REQ-017 SHALL perform register writes on the clock edge that asserts wb_ack, updating only the byte lanes whose wb_sel bit is 1.
REQ-018 SHALL register each irq_src bit every cycle as src_q for edge detection.
REQ-019 For a level-triggered bit (TRIGGER = 0), PENDING SHALL equal the irq_src value registered on the previous edge; W1C writes have no effect.
REQ-020 For an edge-triggered bit (TRIGGER = 1), PENDING SHALL set on the edge where irq_src = 1 and src_q = 0, and SHALL hold until cleared by a 1 written to that PENDING bit.
REQ-021 If a set and a W1C clear of the same PENDING bit occur on the same edge, set SHALL win.
REQ-022 Switching a bit from level to edge SHALL leave PENDING unchanged on that edge; edge detection applies from the next edge.
REQ-023 irq_o SHALL be a registered OR of STATUS, asserting one cycle after any STATUS bit becomes 1 and deasserting one cycle after STATUS becomes all-zero.
REQ-024 CLAIM SHALL read the index+1 of the lowest-numbered set STATUS bit, or 0 when STATUS is zero; reading CLAIM has no side effects.
REQ-025 A source transition occurring during a bus transfer SHALL be captured exactly as in idle cycles.
REQ-026 Latency from an irq_src rising edge (sampled at edge k) to irq_o = 1 SHALL be two cycles (PENDING set after edge k, irq_o after edge k+1) when enabled.

Reset
REQ-027 On wb_clk while wb_rst = 1: PENDING, ENABLE, TRIGGER, src_q, irq_o, wb_ack and wb_rdt SHALL become 0.
REQ-028 A bus cycle in progress when wb_rst asserts SHALL be dropped without an ack; the first cycle after reset deasserts SHALL be idle.

Configuration
REQ-029 With macro WB_IRQ_CTRL_EDGE_EN defined, the TRIGGER register and edge-detection logic (REQ-020..022) SHALL be implemented.
REQ-030 Without WB_IRQ_CTRL_EDGE_EN, all sources SHALL be level-triggered, TRIGGER SHALL read 0 and ignore writes, and src_q logic SHALL be omitted.

Verification
REQ-031 Reset then read offsets 0..4 and 5 -> all read 0x00000000, each ack exactly one cycle wide, irq_o = 0.
REQ-032 ENABLE = 0x05, irq_src = 0x04 held high -> STATUS = 0x04, CLAIM = 3, irq_o = 1 two cycles after irq_src rise; drop irq_src -> irq_o = 0 two cycles later.
REQ-033 (EDGE_EN) TRIGGER = 0x01, ENABLE = 0x01, one-cycle pulse on irq_src[0] -> PENDING = 0x01 persists; write 0x01 to PENDING -> PENDING = 0x00, irq_o = 0 one cycle later.
REQ-034 (EDGE_EN) W1C of PENDING[0] on the same edge as a new rising edge on irq_src[0] -> PENDING[0] stays 1.
REQ-035 Write 0xFFFFFFFF to ENABLE with wb_sel = 4'b0010 and NUM_IRQ = 8 -> ENABLE reads 0x00000000; with wb_sel = 4'b0001 -> reads 0x000000FF.
REQ-036 Assert wb_rst while wb_cyc & wb_stb held and irq_o = 1 -> no ack, irq_o = 0 and all registers 0 on the following cycle.

Source files
------------

// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl: Wishbone-attached interrupt controller.
// Collects NUM_IRQ active-high sources into PENDING and masks them with
// ENABLE to form STATUS. It drives one registered interrupt line, irq_o,
// and offers a CLAIM register that gives the lowest active source.
//
// Register map, decoded on wb_adr[4:2]:
//   0 PENDING  (R/W1C)
//   1 ENABLE   (RW)
//   2 STATUS   (R, PENDING & ENABLE)
//   3 TRIGGER  (RW, 1 = edge)
//   4 CLAIM    (R, index+1 of lowest STATUS bit, 0 if none)
//   5..7       read 0, writes ignored
//
// Optional feature macro: WB_IRQ_CTRL_EDGE_EN.
// When it is defined, the build includes the TRIGGER register and the
// per-source edge detection.
// When it is undefined, every source is level-triggered and TRIGGER reads 0.
module wb_irq_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic [31:0]        wb_adr,
  input  logic [31:0]        wb_dat,
  input  logic [3:0]         wb_sel,
  input  logic               wb_we,
  input  logic               wb_cyc,
  input  logic               wb_stb,
  output logic [31:0]        wb_rdt,
  output logic               wb_ack,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq_o
);

  localparam logic [2:0] OFF_PENDING = 3'd0;
  localparam logic [2:0] OFF_ENABLE  = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_TRIGGER = 3'd3;
  localparam logic [2:0] OFF_CLAIM   = 3'd4;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] trigger;
  logic [NUM_IRQ-1:0] status;
  logic [NUM_IRQ-1:0] wr_mask;
  logic [NUM_IRQ-1:0] wr_bits;
  logic [31:0]        lane_mask;
  logic [31:0]        rd_mux;
  logic [31:0]        claim;
  logic [2:0]         reg_sel;
  logic               bus_req;
  logic               bus_wr;
  logic               wr_enable;
  logic               unused_bits;

  // A new transfer is accepted only when no ack is outstanding.
  // This keeps ack one cycle wide and never back-to-back.
  assign bus_req   = wb_cyc & wb_stb & ~wb_ack;
  assign bus_wr    = bus_req & wb_we;
  assign reg_sel   = wb_adr[4:2];
  assign wr_enable = bus_wr && (reg_sel == OFF_ENABLE);

  // Byte-lane write mask; only the low NUM_IRQ bits are backed by storage.
  assign lane_mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}}, {8{wb_sel[1]}}, {8{wb_sel[0]}}};
  assign wr_mask   = lane_mask[NUM_IRQ-1:0];
  assign wr_bits   = wb_dat[NUM_IRQ-1:0];

  // Address bits outside [4:2] and data/lanes above NUM_IRQ carry no function.
  assign unused_bits = ^{wb_adr[31:5], wb_adr[1:0], wb_dat, lane_mask};

  assign status = pending & enable;

`ifdef WB_IRQ_CTRL_EDGE_EN
  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] trigger_next;
  logic [NUM_IRQ-1:0] trig_rise;
  logic [NUM_IRQ-1:0] edge_set;
  logic [NUM_IRQ-1:0] w1c_clr;
  logic               wr_trigger;
  logic               wr_pending;

  assign wr_trigger = bus_wr && (reg_sel == OFF_TRIGGER);
  assign wr_pending = bus_wr && (reg_sel == OFF_PENDING);

  // Previous-cycle copy of every source, used for rising-edge detection.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) src_q <= '0;
    else        src_q <= irq_src;
  end

  // Compute the TRIGGER value after this edge, and mark bits moving from level to edge.
  always_comb begin
    trigger_next = trigger;
    if (wr_trigger) trigger_next = (trigger & ~wr_mask) | (wr_bits & wr_mask);
    trig_rise = trigger_next & ~trigger;
  end

  // TRIGGER register, byte-lane writable.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) trigger <= '0;
    else        trigger <= trigger_next;
  end

  // Per-bit PENDING update:
  //   - a bit switching to edge holds its value;
  //   - edge bits set on a rise and clear on W1C, and the set wins;
  //   - level bits follow the source.
  always_comb begin
    edge_set     = irq_src & ~src_q;
    w1c_clr      = wr_pending ? (wr_bits & wr_mask) : '0;
    pending_next = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (trig_rise[i])     pending_next[i] = pending[i];
      else if (trigger[i])  pending_next[i] = edge_set[i] | (pending[i] & ~w1c_clr[i]);
      else                  pending_next[i] = irq_src[i];
    end
  end
`else
  assign trigger      = '0;
  assign pending_next = irq_src;
`endif

  // PENDING register, fed by the trigger-dependent next-state logic.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) pending <= '0;
    else        pending <= pending_next;
  end

  // ENABLE register, byte-lane writable on the accepting edge.
  always_ff @(posedge wb_clk) begin
    if (wb_rst)         enable <= '0;
    else if (wr_enable) enable <= (enable & ~wr_mask) | (wr_bits & wr_mask);
  end

  // Registered OR of STATUS drives the core's external interrupt line.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) irq_o <= 1'b0;
    else        irq_o <= |status;
  end

  // Priority encoder: the lowest set STATUS bit wins. Reading it has no side effects.
  always_comb begin
    claim = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (status[i]) claim = 32'(i + 1);
    end
  end

  // Read multiplexer; unbacked bits and unmapped offsets return 0.
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      OFF_PENDING: rd_mux[NUM_IRQ-1:0] = pending;
      OFF_ENABLE:  rd_mux[NUM_IRQ-1:0] = enable;
      OFF_STATUS:  rd_mux[NUM_IRQ-1:0] = status;
      OFF_TRIGGER: rd_mux[NUM_IRQ-1:0] = trigger;
      OFF_CLAIM:   rd_mux              = claim;
      default:     rd_mux              = '0;
    endcase
  end

  // Bus response: ack one cycle after acceptance, with read data valid only in the ack cycle.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack <= 1'b0;
      wb_rdt <= '0;
    end else begin
      wb_ack <= bus_req;
      wb_rdt <= bus_req ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb_wb_irq_ctrl: directed self-checking bench for wb_irq_ctrl (NUM_IRQ = 8).
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
// Edge-trigger steps are included only when WB_IRQ_CTRL_EDGE_EN is defined.
module tb_wb_irq_ctrl;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [7:0]  irq_src;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  wb_irq_ctrl #(.NUM_IRQ(8)) dut (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .wb_adr  (wb_adr),
    .wb_dat  (wb_dat),
    .wb_sel  (wb_sel),
    .wb_we   (wb_we),
    .wb_cyc  (wb_cyc),
    .wb_stb  (wb_stb),
    .wb_rdt  (wb_rdt),
    .wb_ack  (wb_ack),
    .irq_src (irq_src),
    .irq_o   (irq_o)
  );

  // 10-time-unit clock period.
  always #5 wb_clk = ~wb_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One Wishbone transfer. The task is entered and left on a falling edge.
  // It checks that ack is high for exactly one cycle.
  // On a read it also checks the data returned in the ack cycle.
  task automatic applyStimulus(input logic we, input logic [2:0] off,
                               input logic [31:0] data, input logic [3:0] sel,
                               input string tag, input logic [31:0] exp_rd);
    wb_cyc = 1'b1;
    wb_stb = 1'b1;
    wb_we  = we;
    wb_adr = {27'd0, off, 2'b00};
    wb_dat = data;
    wb_sel = sel;
    @(negedge wb_clk);
    checkOutput({tag, "_ack"}, 32'(wb_ack), 32'd1);
    if (!we) checkOutput({tag, "_rdt"}, wb_rdt, exp_rd);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_we  = 1'b0;
    @(negedge wb_clk);
    checkOutput({tag, "_ack_low"}, 32'(wb_ack), 32'd0);
    checkOutput({tag, "_rdt_idle"}, wb_rdt, 32'd0);
  endtask

  task automatic wbWrite(input logic [2:0] off, input logic [31:0] data,
                         input logic [3:0] sel, input string tag);
    applyStimulus(1'b1, off, data, sel, tag, 32'd0);
  endtask

  task automatic wbRead(input logic [2:0] off, input string tag,
                        input logic [31:0] expected);
    applyStimulus(1'b0, off, 32'd0, 4'b0000, tag, expected);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  initial begin
    wb_rst  = 1'b1;
    wb_adr  = '0;
    wb_dat  = '0;
    wb_sel  = '0;
    wb_we   = 1'b0;
    wb_cyc  = 1'b0;
    wb_stb  = 1'b0;
    irq_src = '0;

    // Reset state.
    idleCycles(3);
    checkOutput("rst_ack", 32'(wb_ack), 32'd0);
    checkOutput("rst_rdt", wb_rdt, 32'd0);
    checkOutput("rst_irq", 32'(irq_o), 32'd0);
    wb_rst = 1'b0;
    idleCycles(1);

    // Every offset reads zero after reset, including an unmapped one.
    wbRead(3'd0, "rd_pending0", 32'd0);
    wbRead(3'd1, "rd_enable0", 32'd0);
    wbRead(3'd2, "rd_status0", 32'd0);
    wbRead(3'd3, "rd_trigger0", 32'd0);
    wbRead(3'd4, "rd_claim0", 32'd0);
    wbRead(3'd5, "rd_off5_0", 32'd0);
    checkOutput("irq_after_rst", 32'(irq_o), 32'd0);

    // Level source on bit 2 with ENABLE = 0x05: two-cycle latency to irq_o.
    wbWrite(3'd1, 32'h0000_0005, 4'b1111, "wr_enable05");
    irq_src = 8'h04;
    idleCycles(1);
    checkOutput("irq_lat1", 32'(irq_o), 32'd0);
    idleCycles(1);
    checkOutput("irq_lat2", 32'(irq_o), 32'd1);
    wbRead(3'd0, "pending04", 32'h0000_0004);
    wbRead(3'd2, "status04", 32'h0000_0004);
    wbRead(3'd4, "claim3", 32'd3);
    wbRead(3'd1, "enable05", 32'h0000_0005);
    // A W1C write has no effect on a level-triggered bit.
    wbWrite(3'd0, 32'h0000_0004, 4'b1111, "w1c_level");
    wbRead(3'd0, "pending_level_kept", 32'h0000_0004);
    irq_src = 8'h00;
    idleCycles(1);
    checkOutput("irq_drop1", 32'(irq_o), 32'd1);
    idleCycles(1);
    checkOutput("irq_drop2", 32'(irq_o), 32'd0);

    // Claim priority, and masking of a disabled source.
    irq_src = 8'h05;
    idleCycles(2);
    wbRead(3'd2, "status05", 32'h0000_0005);
    wbRead(3'd4, "claim1", 32'd1);
    irq_src = 8'h02;
    idleCycles(2);
    wbRead(3'd2, "status_masked", 32'd0);
    wbRead(3'd4, "claim_none", 32'd0);
    wbRead(3'd0, "pending02", 32'h0000_0002);
    checkOutput("irq_masked", 32'(irq_o), 32'd0);

    // The highest source index yields CLAIM = NUM_IRQ.
    wbWrite(3'd1, 32'h0000_0080, 4'b1111, "wr_enable80");
    irq_src = 8'h80;
    idleCycles(2);
    wbRead(3'd4, "claim8", 32'd8);
    irq_src = 8'h00;

    // Byte-lane masking on ENABLE.
    wbWrite(3'd1, 32'h0000_0000, 4'b1111, "wr_enable_clr");
    wbWrite(3'd1, 32'hFFFF_FFFF, 4'b0010, "wr_enable_lane1");
    wbRead(3'd1, "enable_lane1", 32'd0);
    wbWrite(3'd1, 32'hFFFF_FFFF, 4'b0001, "wr_enable_lane0");
    wbRead(3'd1, "enable_lane0", 32'h0000_00FF);

    // Unmapped and read-only offsets ignore writes.
    wbWrite(3'd5, 32'hFFFF_FFFF, 4'b1111, "wr_off5");
    wbRead(3'd5, "off5_ignored", 32'd0);
    wbWrite(3'd2, 32'hFFFF_FFFF, 4'b1111, "wr_status");
    wbRead(3'd2, "status_ignored", 32'd0);

`ifdef WB_IRQ_CTRL_EDGE_EN
    // Edge source on bit 0: a one-cycle pulse latches, and W1C clears it.
    wbWrite(3'd1, 32'h0000_0001, 4'b1111, "wr_enable01");
    wbWrite(3'd3, 32'h0000_0001, 4'b1111, "wr_trigger01");
    wbRead(3'd3, "trigger01", 32'h0000_0001);
    irq_src = 8'h01;
    idleCycles(1);
    irq_src = 8'h00;
    idleCycles(3);
    wbRead(3'd0, "edge_latched", 32'h0000_0001);
    checkOutput("edge_irq", 32'(irq_o), 32'd1);
    wbWrite(3'd0, 32'h0000_0001, 4'b1111, "w1c_edge");
    checkOutput("edge_irq_cleared", 32'(irq_o), 32'd0);
    wbRead(3'd0, "edge_cleared", 32'd0);

    // A set and a W1C clear on the same edge: the set wins.
    irq_src = 8'h01;
    idleCycles(1);
    irq_src = 8'h00;
    idleCycles(2);
    irq_src = 8'h01;
    wbWrite(3'd0, 32'h0000_0001, 4'b1111, "w1c_vs_set");
    irq_src = 8'h00;
    wbRead(3'd0, "set_wins", 32'h0000_0001);
    checkOutput("set_wins_irq", 32'(irq_o), 32'd1);

    // Switching bit 1 to edge on the same edge as a source rise keeps PENDING[1] clear.
    irq_src = 8'h02;
    wbWrite(3'd3, 32'h0000_0003, 4'b1111, "wr_trigger03");
    irq_src = 8'h00;
    wbRead(3'd0, "switch_held", 32'h0000_0001);
    wbRead(3'd3, "trigger03", 32'h0000_0003);
    irq_src = 8'h02;
    idleCycles(1);
    irq_src = 8'h00;
    idleCycles(1);
    wbRead(3'd0, "edge_bit1", 32'h0000_0003);
`else
    // Without edge support, TRIGGER ignores writes.
    wbWrite(3'd3, 32'hFFFF_FFFF, 4'b1111, "wr_trigger");
    wbRead(3'd3, "trigger_ignored", 32'd0);
`endif

    // Reset in the middle of a bus cycle while irq_o is high.
    irq_src = 8'h01;
    idleCycles(2);
    checkOutput("pre_rst_irq", 32'(irq_o), 32'd1);
    irq_src = 8'h00;
    wb_cyc  = 1'b1;
    wb_stb  = 1'b1;
    wb_adr  = 32'h0000_0004;
    wb_rst  = 1'b1;
    idleCycles(1);
    checkOutput("midrst_ack", 32'(wb_ack), 32'd0);
    checkOutput("midrst_irq", 32'(irq_o), 32'd0);
    checkOutput("midrst_rdt", wb_rdt, 32'd0);
    idleCycles(1);
    checkOutput("midrst_ack2", 32'(wb_ack), 32'd0);
    wb_cyc = 1'b0;
    wb_stb = 1'b0;
    wb_rst = 1'b0;
    idleCycles(1);
    checkOutput("post_rst_ack", 32'(wb_ack), 32'd0);
    wbRead(3'd0, "post_pending", 32'd0);
    wbRead(3'd1, "post_enable", 32'd0);
    wbRead(3'd2, "post_status", 32'd0);
    wbRead(3'd3, "post_trigger", 32'd0);
    checkOutput("post_irq", 32'(irq_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
